// File: rtl/lsu_mem_unit_if.sv
// lsu_mem_unit_if: shared types plus the LSQ/memory/CDB bus bundle of the memory-side executor
package uarch_pkg;
  localparam int CPU_DATA_BITS = 32;
  localparam int TAG_WIDTH = 6;
  typedef struct packed {
    logic                     is_valid;
    logic [TAG_WIDTH-1:0]     dest_tag;
    logic [CPU_DATA_BITS-1:0] result;
    logic                     exception;
  } writeback_packet_t;
endpackage

interface lsu_mem_unit_if;
  import uarch_pkg::*;
  logic                     flush;
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_is_store;
  logic [1:0]               req_size;
  logic                     req_unsigned;
  logic [CPU_DATA_BITS-1:0] req_addr;
  logic [CPU_DATA_BITS-1:0] req_wdata;
  logic [TAG_WIDTH-1:0]     req_tag;
  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic                     mem_we;
  logic [CPU_DATA_BITS-1:0] mem_addr;
  logic [CPU_DATA_BITS-1:0] mem_wdata;
  logic [3:0]               mem_wstrb;
  logic                     mem_resp_valid;
  logic [CPU_DATA_BITS-1:0] mem_rdata;
  writeback_packet_t        wb_pkt;
  logic                     wb_ready;
  modport slave (
    input  flush, req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata, req_tag,
    input  mem_req_ready, mem_resp_valid, mem_rdata, wb_ready,
    output req_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, wb_pkt
  );
  modport master (
    output flush, req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata, req_tag,
    output mem_req_ready, mem_resp_valid, mem_rdata, wb_ready,
    input  req_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, wb_pkt
  );
endinterface

// File: rtl/lsu_mem_unit.sv
// lsu_mem_unit: executes one resolved load/store against a variable-latency data memory and returns a writeback packet
module lsu_mem_unit
  import uarch_pkg::*;
(
  input logic clk,
  input logic rst,
  lsu_mem_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, WB, DRAIN} state_e;
  state_e state_q, state_d;
  logic is_store_q, unsigned_q;
  logic [1:0] size_q;
  logic [CPU_DATA_BITS-1:0] addr_q, wdata_q, ld_val;
  logic [TAG_WIDTH-1:0] tag_q;
  writeback_packet_t wb_q, wb_d, new_pkt;
  logic mis, accept, in_req;
  logic [7:0] ld_b;
  logic [15:0] ld_h;
  assign mis = (bus.req_size == 2'd3) || (bus.req_size == 2'd1 && bus.req_addr[0]) ||
               (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'd0);
  assign accept = state_q == IDLE && bus.req_valid && !bus.flush;
  assign in_req = state_q == REQ;
  assign ld_b = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign ld_h = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  // next state; a flush after the memory handshake must still swallow the owed response
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = accept ? (mis ? WB : REQ) : IDLE;
      REQ:   state_d = !bus.mem_req_ready ? (bus.flush ? IDLE : REQ) :
                       bus.mem_resp_valid ? (bus.flush ? IDLE : WB) : (bus.flush ? DRAIN : WAIT);
      WAIT:  state_d = bus.mem_resp_valid ? (bus.flush ? IDLE : WB) : (bus.flush ? DRAIN : WAIT);
      WB:    state_d = (bus.flush || bus.wb_ready) ? IDLE : WB;
      DRAIN: state_d = bus.mem_resp_valid ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  // op fields captured on acceptance, writeback packet registered
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      is_store_q <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= 2'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      tag_q      <= '0;
      wb_q       <= '0;
    end else begin
      wb_q <= wb_d;
      if (accept) begin
        is_store_q <= bus.req_is_store;
        unsigned_q <= bus.req_unsigned;
        size_q     <= bus.req_size;
        addr_q     <= bus.req_addr;
        wdata_q    <= bus.req_wdata;
        tag_q      <= bus.req_tag;
      end
    end
  // load alignment/extension and writeback packet formation; entering WB from IDLE means misaligned
  always_comb begin
    ld_val = size_q == 2'd0 ? {{24{ld_b[7] & ~unsigned_q}}, ld_b} :
             size_q == 2'd1 ? {{16{ld_h[15] & ~unsigned_q}}, ld_h} : bus.mem_rdata;
    new_pkt.is_valid  = 1'b1;
    new_pkt.dest_tag  = state_q == IDLE ? bus.req_tag : tag_q;
    new_pkt.result    = state_q == IDLE ? bus.req_addr : is_store_q ? '0 : ld_val;
    new_pkt.exception = state_q == IDLE;
    wb_d = state_d != WB ? '0 : state_q == WB ? wb_q : new_pkt;
  end
  // outputs; memory bus is driven only while requesting so it idles at zero
  always_comb begin
    bus.req_ready     = rst && state_q == IDLE;
    bus.mem_req_valid = in_req;
    bus.mem_we        = in_req && is_store_q;
    bus.mem_addr      = in_req ? {addr_q[CPU_DATA_BITS-1:2], 2'b00} : '0;
    bus.mem_wstrb     = !in_req ? 4'b0000 : size_q == 2'd0 ? 4'b0001 << addr_q[1:0] :
                        size_q == 2'd1 ? 4'b0011 << addr_q[1:0] : 4'b1111;
    bus.mem_wdata     = !in_req ? '0 : size_q == 2'd0 ? {4{wdata_q[7:0]}} :
                        size_q == 2'd1 ? {2{wdata_q[15:0]}} : wdata_q;
    bus.wb_pkt        = wb_q;
  end
endmodule

// File: tb/tb_lsu_mem_unit.sv
// tb_lsu_mem_unit: vector table plus flush/reset sequences with a writeback scoreboard
module tb_lsu_mem_unit;
  import uarch_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  lsu_mem_unit_if bus();
  lsu_mem_unit dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] addr, wdata, rdata;
    logic        exc;
    logic [31:0] res;
    logic [3:0]  strb;
    logic [31:0] mwd;
  } vec_t;

  int n_run = 0, n_fail = 0, cur = -1;
  writeback_packet_t sb[$];
  vec_t vt[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (item %0d): got %h expected %h", nm, cur, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v, input logic [5:0] tag);
    bus.req_valid = 1'b1;
    bus.req_is_store = v.st;
    bus.req_size = v.sz;
    bus.req_unsigned = v.un;
    bus.req_addr = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_tag = tag;
  endtask

  task automatic run_op(input vec_t v, input logic [5:0] tag, input int stall, input int wstall);
    writeback_packet_t e;
    int lat;
    @(negedge clk);
    drive_req(v, tag);
    chk("req_ready", bus.req_ready, 1);
    e.is_valid = 1'b1;
    e.dest_tag = tag;
    e.result = v.res;
    e.exception = v.exc;
    sb.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    if (!v.exc) begin
      for (int i = 0; i < stall; i++) begin
        chk("stall_mem_valid", bus.mem_req_valid, 1);
        chk("stall_mem_addr", bus.mem_addr, v.addr & ~32'h3);
        chk("stall_req_ready", bus.req_ready, 0);
        @(negedge clk);
        lat++;
      end
      chk("mem_req_valid", bus.mem_req_valid, 1);
      chk("mem_addr", bus.mem_addr, v.addr & ~32'h3);
      chk("mem_we", bus.mem_we, v.st);
      if (v.st) begin
        chk("mem_wstrb", bus.mem_wstrb, v.strb);
        chk("mem_wdata", bus.mem_wdata, v.mwd);
      end
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      lat++;
      bus.mem_req_ready = 1'b0;
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata = v.rdata;
      @(negedge clk);
      lat++;
      bus.mem_resp_valid = 1'b0;
    end else chk("misaligned_no_mem", bus.mem_req_valid, 0);
    for (int i = 0; i < 8 && !bus.wb_pkt.is_valid; i++) begin
      @(negedge clk);
      lat++;
    end
    chk("wb_arrived", bus.wb_pkt.is_valid, 1);
    chk("wb_latency", lat, v.exc ? 1 : 3 + stall);
    for (int i = 0; i < wstall; i++) begin
      chk("wb_hold", bus.wb_pkt, sb[0]);
      chk("wb_hold_req_ready", bus.req_ready, 0);
      @(negedge clk);
    end
    bus.wb_ready = 1'b1;
    e = sb.pop_front();
    chk("wb_pkt", bus.wb_pkt, e);
    @(negedge clk);
    bus.wb_ready = 1'b0;
    chk("wb_consumed", bus.wb_pkt.is_valid, 0);
    chk("ready_again", bus.req_ready, 1);
  endtask

  task automatic accept_lw();
    @(negedge clk);
    drive_req(vt[0], 6'd9);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  initial begin
    vt[0]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 4'h0, 32'h0};
    vt[1]  = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FFFF7F, 1'b0, 32'hFFFFFF80, 4'h0, 32'h0};
    vt[2]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FFFF7F, 1'b0, 32'h00000080, 4'h0, 32'h0};
    vt[3]  = '{1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h80FFFF7F, 1'b0, 32'hFFFF80FF, 4'h0, 32'h0};
    vt[4]  = '{1'b1, 2'd0, 1'b0, 32'h201, 32'hAB, 32'h12345678, 1'b0, 32'h0, 4'b0010, 32'hABABABAB};
    vt[5]  = '{1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 32'h102, 4'h0, 32'h0};
    vt[6]  = '{1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 32'h101, 4'h0, 32'h0};
    vt[7]  = '{1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 32'h100, 4'h0, 32'h0};
    vt[8]  = '{1'b1, 2'd1, 1'b0, 32'h202, 32'hFFFF1234, 32'h55555555, 1'b0, 32'h0, 4'b1100, 32'h12341234};
    vt[9]  = '{1'b1, 2'd2, 1'b0, 32'h300, 32'hCAFEF00D, 32'h0, 1'b0, 32'h0, 4'b1111, 32'hCAFEF00D};
    vt[10] = '{1'b0, 2'd1, 1'b1, 32'h100, 32'h0, 32'h7FFF8001, 1'b0, 32'h00008001, 4'h0, 32'h0};
    vt[11] = '{1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 32'h00008000, 1'b0, 32'hFFFFFF80, 4'h0, 32'h0};
    bus.flush = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.req_tag = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata = '0;
    bus.wb_ready = 1'b0;
    #12;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_mem_req_valid", bus.mem_req_valid, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wstrb", bus.mem_wstrb, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_wb_pkt", bus.wb_pkt, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", bus.req_ready, 1);
    for (int i = 0; i < 12; i++) begin
      cur = i;
      run_op(vt[i], 6'(i + 1), 0, 0);
    end
    cur = 100;
    run_op(vt[0], 6'd33, 4, 3);
    cur = 101;
    run_op(vt[4], 6'd34, 2, 1);
    cur = 200;
    accept_lw();
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    drive_req(vt[1], 6'd20);
    chk("drain_req_ready", bus.req_ready, 0);
    chk("drain_mem_req_valid", bus.mem_req_valid, 0);
    @(negedge clk);
    chk("drain_req_ready2", bus.req_ready, 0);
    bus.req_valid = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    chk("drained_req_ready", bus.req_ready, 1);
    chk("drained_no_wb", bus.wb_pkt.is_valid, 0);
    @(negedge clk);
    chk("drained_no_wb2", bus.wb_pkt.is_valid, 0);
    cur = 201;
    accept_lw();
    bus.flush = 1'b1;
    chk("req_flush_valid_now", bus.mem_req_valid, 1);
    @(negedge clk);
    bus.flush = 1'b0;
    chk("req_flush_cancel", bus.mem_req_valid, 0);
    chk("req_flush_idle", bus.req_ready, 1);
    cur = 202;
    accept_lw();
    bus.flush = 1'b1;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.mem_req_ready = 1'b0;
    chk("hs_flush_drain", bus.req_ready, 0);
    chk("hs_flush_mem_valid", bus.mem_req_valid, 0);
    bus.mem_resp_valid = 1'b1;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    chk("hs_flush_idle", bus.req_ready, 1);
    chk("hs_flush_no_wb", bus.wb_pkt.is_valid, 0);
    cur = 203;
    @(negedge clk);
    drive_req(vt[0], 6'd21);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.flush = 1'b0;
    chk("idle_flush_not_accepted", bus.mem_req_valid, 0);
    chk("idle_flush_ready", bus.req_ready, 1);
    cur = 204;
    @(negedge clk);
    drive_req(vt[5], 6'd22);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("wb_before_flush", bus.wb_pkt.is_valid, 1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("wb_flushed", bus.wb_pkt.is_valid, 0);
    chk("wb_flush_ready", bus.req_ready, 1);
    cur = 205;
    bus.mem_resp_valid = 1'b1;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    chk("idle_resp_ignored", bus.wb_pkt.is_valid, 0);
    chk("idle_resp_ready", bus.req_ready, 1);
    cur = 206;
    accept_lw();
    chk("pre_reset_mem_valid", bus.mem_req_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_mem_valid", bus.mem_req_valid, 0);
    chk("async_rst_req_ready", bus.req_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("after_rst_ready", bus.req_ready, 1);
    chk("after_rst_mem_valid", bus.mem_req_valid, 0);
    cur = 207;
    run_op(vt[3], 6'd40, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
